// File: rtl/strobe_div.sv
// Programmable strobe divider: one-cycle strobe every div_act enabled cycles,
// with glitch-free divisor reloads at period boundaries and external sync alignment.
module strobe_div #(
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 80000000,
    parameter bit SYNC_EN     = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    input  logic             sync_in,
    output logic             strobe,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] phase,
    output logic             phase_valid,
    output logic             locked,
    output logic             div_err
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    // Divisors of 0 or 1 cannot produce a one-cycle strobe between idle cycles.
    function automatic logic div_legal(input logic [WIDTH-1:0] d);
        return d >= WIDTH'(2);
    endfunction

    logic             sync_d;
    logic             pend;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_shadow;

    logic at_end;
    logic sync_edge;
    logic restart;
    logic load_ok;
    logic load_bad;

    always_comb begin
        at_end    = (count == div_act - WIDTH'(1));
        sync_edge = SYNC_EN && en && sync_in && !sync_d;
        restart   = en && (at_end || sync_edge);
        load_ok   = div_load && div_legal(div_in);
        load_bad  = div_load && !div_legal(div_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            strobe      <= 1'b0;
            sync_d      <= 1'b0;
            phase       <= '0;
            phase_valid <= 1'b0;
            locked      <= 1'b0;
        end else begin
            sync_d      <= sync_in;
            strobe      <= restart;
            phase_valid <= sync_edge;
            if (en) begin
                count <= restart ? '0 : count + WIDTH'(1);
            end
            // A sync edge that lands on the natural wrap cycle means we are already aligned.
            if (sync_edge) begin
                phase  <= count;
                locked <= at_end;
            end
        end
    end

    // The restart consumes the previously staged divisor; a load in the same
    // cycle is written after it and therefore stays pending for the next period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_act    <= DIV_RST;
            div_shadow <= DIV_RST;
            pend       <= 1'b0;
            div_err    <= 1'b0;
        end else begin
            if (restart && pend) begin
                div_act <= div_shadow;
                pend    <= 1'b0;
            end
            if (load_ok) begin
                div_shadow <= div_in;
                pend       <= 1'b1;
            end
            if (load_bad) begin
                div_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_strobe_div.sv
// Directed self-checking bench for strobe_div with an 8-bit counter and a default divisor of 4.
module tb_strobe_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         sync_in;
    logic         strobe;
    logic [W-1:0] count;
    logic [W-1:0] phase;
    logic         phase_valid;
    logic         locked;
    logic         div_err;

    int vectors = 0;
    int miscompares = 0;

    strobe_div #(.WIDTH(W), .DEFAULT_DIV(4), .SYNC_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
        .sync_in(sync_in), .strobe(strobe), .count(count), .phase(phase),
        .phase_valid(phase_valid), .locked(locked), .div_err(div_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; div_in = '0; div_load = 1'b0; sync_in = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (count !== 8'd0 || strobe !== 1'b0 || phase !== 8'd0 ||
            phase_valid !== 1'b0 || locked !== 1'b0 || div_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: count=%0d strobe=%b phase=%0d pv=%b locked=%b err=%b, required all zero",
                     count, strobe, phase, phase_valid, locked, div_err);
        end
    endtask

    task automatic test_default_period();
        rst = 1'b0; en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            vectors++;
            if (count !== W'(i % 4) || strobe !== (i % 4 == 0)) begin
                miscompares++;
                $display("FAIL default_period step %0d: count=%0d strobe=%b, required count=%0d strobe=%b",
                         i, count, strobe, i % 4, (i % 4 == 0));
            end
        end
    endtask

    task automatic test_div_change();
        // Entered at count 0 with div_act 4; load 6 while count is 1.
        tick();
        div_in = 8'd6; div_load = 1'b1;
        tick();
        div_load = 1'b0;
        vectors++;
        if (count !== 8'd2 || strobe !== 1'b0) begin
            miscompares++;
            $display("FAIL div_change_load: count=%0d strobe=%b, required count=2 strobe=0", count, strobe);
        end
        tick();
        tick();
        vectors++;
        if (count !== 8'd0 || strobe !== 1'b1) begin
            miscompares++;
            $display("FAIL div_change_old_period: count=%0d strobe=%b, required count=0 strobe=1", count, strobe);
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            vectors++;
            if (count !== W'(i % 6) || strobe !== (i % 6 == 0)) begin
                miscompares++;
                $display("FAIL div_change_new_period step %0d: count=%0d strobe=%b, required count=%0d strobe=%b",
                         i, count, strobe, i % 6, (i % 6 == 0));
            end
        end
    endtask

    task automatic test_div_err();
        // Entered at count 0 with div_act 6.
        div_in = 8'd1; div_load = 1'b1;
        tick();
        div_load = 1'b0;
        vectors++;
        if (div_err !== 1'b1 || count !== 8'd1) begin
            miscompares++;
            $display("FAIL div_err_set: div_err=%b count=%0d, required div_err=1 count=1", div_err, count);
        end
        repeat (5) tick();
        vectors++;
        if (count !== 8'd0 || strobe !== 1'b1) begin
            miscompares++;
            $display("FAIL div_err_period_kept: count=%0d strobe=%b, required count=0 strobe=1", count, strobe);
        end
        div_in = 8'd5; div_load = 1'b1;
        tick();
        div_load = 1'b0;
        repeat (5) tick();
        vectors++;
        if (count !== 8'd0 || strobe !== 1'b1 || div_err !== 1'b1) begin
            miscompares++;
            $display("FAIL div_err_sticky: count=%0d strobe=%b div_err=%b, required count=0 strobe=1 div_err=1",
                     count, strobe, div_err);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            vectors++;
            if (count !== W'(i % 5) || strobe !== (i % 5 == 0)) begin
                miscompares++;
                $display("FAIL div5_period step %0d: count=%0d strobe=%b, required count=%0d strobe=%b",
                         i, count, strobe, i % 5, (i % 5 == 0));
            end
        end
    endtask

    task automatic test_sync_mid();
        // Entered at count 0 with div_act 5; switch to 8, then sync at count 5.
        div_in = 8'd8; div_load = 1'b1;
        tick();
        div_load = 1'b0;
        repeat (4) tick();
        repeat (5) tick();
        vectors++;
        if (count !== 8'd5) begin
            miscompares++;
            $display("FAIL sync_mid_setup: count=%0d, required 5", count);
        end
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        vectors++;
        if (count !== 8'd0 || strobe !== 1'b1 || phase !== 8'd5 ||
            phase_valid !== 1'b1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_mid_edge: count=%0d strobe=%b phase=%0d pv=%b locked=%b, required 0 1 5 1 0",
                     count, strobe, phase, phase_valid, locked);
        end
        tick();
        vectors++;
        if (count !== 8'd1 || strobe !== 1'b0 || phase_valid !== 1'b0 || phase !== 8'd5) begin
            miscompares++;
            $display("FAIL sync_mid_after: count=%0d strobe=%b pv=%b phase=%0d, required 1 0 0 5",
                     count, strobe, phase_valid, phase);
        end
        repeat (7) tick();
        vectors++;
        if (count !== 8'd0 || strobe !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_mid_div8: count=%0d strobe=%b, required count=0 strobe=1", count, strobe);
        end
    endtask

    task automatic test_sync_locked();
        repeat (7) tick();
        sync_in = 1'b1;
        tick();
        vectors++;
        if (count !== 8'd0 || strobe !== 1'b1 || phase !== 8'd7 ||
            phase_valid !== 1'b1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_locked_edge: count=%0d strobe=%b phase=%0d pv=%b locked=%b, required 0 1 7 1 1",
                     count, strobe, phase, phase_valid, locked);
        end
        tick();
        vectors++;
        if (strobe !== 1'b0 || count !== 8'd1) begin
            miscompares++;
            $display("FAIL sync_locked_single: strobe=%b count=%0d, required strobe=0 count=1", strobe, count);
        end
        for (int j = 2; j <= 19; j++) begin
            tick();
            vectors++;
            if (phase_valid !== 1'b0 || phase !== 8'd7 || locked !== 1'b1 || count !== W'(j % 8)) begin
                miscompares++;
                $display("FAIL sync_held step %0d: pv=%b phase=%0d locked=%b count=%0d, required 0 7 1 %0d",
                         j, phase_valid, phase, locked, count, j % 8);
            end
        end
        sync_in = 1'b0;
    endtask

    task automatic test_enable_reset();
        // Entered at count 3; advance to count 2.
        repeat (7) tick();
        vectors++;
        if (count !== 8'd2) begin
            miscompares++;
            $display("FAIL hold_setup: count=%0d, required 2", count);
        end
        en = 1'b0; sync_in = 1'b1; div_in = 8'd3; div_load = 1'b1;
        tick();
        sync_in = 1'b0; div_load = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) tick();
            vectors++;
            if (count !== 8'd2 || strobe !== 1'b0 || phase_valid !== 1'b0 || phase !== 8'd7) begin
                miscompares++;
                $display("FAIL hold cycle %0d: count=%0d strobe=%b pv=%b phase=%0d, required 2 0 0 7",
                         k, count, strobe, phase_valid, phase);
            end
        end
        en = 1'b1;
        tick();
        vectors++;
        if (count !== 8'd3) begin
            miscompares++;
            $display("FAIL resume: count=%0d, required 3", count);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (count !== 8'd0 || strobe !== 1'b0 || phase !== 8'd0 ||
            phase_valid !== 1'b0 || locked !== 1'b0 || div_err !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: count=%0d strobe=%b phase=%0d pv=%b locked=%b err=%b, required all zero",
                     count, strobe, phase, phase_valid, locked, div_err);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            vectors++;
            if (count !== W'(i % 4) || strobe !== (i % 4 == 0)) begin
                miscompares++;
                $display("FAIL post_reset step %0d: count=%0d strobe=%b, required count=%0d strobe=%b",
                         i, count, strobe, i % 4, (i % 4 == 0));
            end
        end
    endtask

    task automatic test_back_to_back();
        // Entered at count 0 with div_act 4: two loads in one period, last wins.
        tick();
        div_in = 8'd5; div_load = 1'b1;
        tick();
        div_in = 8'd7;
        tick();
        div_load = 1'b0;
        tick();
        vectors++;
        if (count !== 8'd0 || strobe !== 1'b1) begin
            miscompares++;
            $display("FAIL last_wins_old_period: count=%0d strobe=%b, required 0 1", count, strobe);
        end
        for (int i = 1; i <= 7; i++) begin
            tick();
            vectors++;
            if (count !== W'(i % 7) || strobe !== (i % 7 == 0)) begin
                miscompares++;
                $display("FAIL last_wins step %0d: count=%0d strobe=%b, required count=%0d strobe=%b",
                         i, count, strobe, i % 7, (i % 7 == 0));
            end
        end
        // Load 3 on the wrap cycle: the following period stays 7, then 3.
        repeat (6) tick();
        div_in = 8'd3; div_load = 1'b1;
        tick();
        div_load = 1'b0;
        vectors++;
        if (count !== 8'd0 || strobe !== 1'b1) begin
            miscompares++;
            $display("FAIL load_on_wrap: count=%0d strobe=%b, required 0 1", count, strobe);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            vectors++;
            if (i <= 7) begin
                if (count !== W'(i % 7) || strobe !== (i == 7)) begin
                    miscompares++;
                    $display("FAIL load_on_wrap_p7 step %0d: count=%0d strobe=%b, required count=%0d strobe=%b",
                             i, count, strobe, i % 7, (i == 7));
                end
            end else begin
                if (count !== W'((i - 7) % 3) || strobe !== (i == 10)) begin
                    miscompares++;
                    $display("FAIL load_on_wrap_p3 step %0d: count=%0d strobe=%b, required count=%0d strobe=%b",
                             i, count, strobe, (i - 7) % 3, (i == 10));
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_default_period();
        test_div_change();
        test_div_err();
        test_sync_mid();
        test_sync_locked();
        test_enable_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/strobe_div.md
STROBE_DIV -- requirements
Module: strobe_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 28: width of the counter, the divisor and the phase output.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 80000000: active divisor after reset (valid range 2..2^WIDTH-1).
REQ-003 The block SHALL have parameter SYNC_EN, default 1: 1 enables external sync alignment; 0 ignores sync_in.
REQ-004 The block SHALL run on one clock and use an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: count enable; 0 freezes the counter.
REQ-008 The block SHALL have port div_in, input, WIDTH bits: new divisor value.
REQ-009 The block SHALL have port div_load, input, 1 bit: one-cycle request to stage div_in.
REQ-010 The block SHALL have port sync_in, input, 1 bit: external alignment pulse, already synchronous to clk.
REQ-011 The block SHALL have port strobe, output, 1 bit: one-cycle pulse per period.
REQ-012 The block SHALL have port count, output, WIDTH bits: current counter value.
REQ-013 The block SHALL have port phase, output, WIDTH bits: count captured at the last sync edge.
REQ-014 The block SHALL have port phase_valid, output, 1 bit: one-cycle pulse when phase updates.
REQ-015 The block SHALL have port locked, output, 1 bit: last sync edge coincided with a natural wrap.
REQ-016 The block SHALL have port div_err, output, 1 bit: sticky flag, set when an illegal divisor load is rejected.

Function
REQ-017 All outputs SHALL be registered; divisor in use is div_act, staged value is div_shadow with flag pend.
REQ-018 In each cycle with en=1 and no sync edge, the block SHALL do the following: if count==div_act-1, set count<=0 and strobe<=1, and if pend=1 also set div_act<=div_shadow and pend<=0; otherwise set count<=count+1 and strobe<=0.
REQ-019 In each cycle with en=0, count SHALL hold, strobe SHALL be 0 and sync edges SHALL be ignored.
REQ-020 When div_load=1, a div_in value of 2 or more SHALL set div_shadow<=div_in and pend<=1; a later load before the wrap SHALL overwrite the earlier one (last wins).
REQ-021 When div_load=1 with div_in of 0 or 1, the block SHALL leave div_shadow and pend unchanged and set div_err<=1; div_err SHALL clear only on reset.
REQ-022 A new divisor SHALL never shorten or lengthen the period in progress; it SHALL apply from the first count after the next wrap or sync edge.
REQ-023 Sync edge detection SHALL use sync_d, the sync_in value registered on the previous clock; an edge is sync_in=1 with sync_d=0, when SYNC_EN=1 and en=1.
REQ-024 On a sync edge, the block SHALL set count<=0, strobe<=1, phase<=count, phase_valid<=1 and locked<=(count==div_act-1); a pending divisor SHALL apply as on a wrap.
REQ-025 A sync edge SHALL take priority over a natural wrap in the same cycle, giving a single strobe, never two.
REQ-026 phase_valid SHALL be 0 in every cycle except the one following a sync edge; phase and locked SHALL hold between sync edges.
REQ-027 A sync_in held high SHALL produce exactly one edge.
REQ-028 When div_load and a wrap occur in the same cycle, the wrap SHALL use the old pend/div_shadow, and the new load SHALL become pending for the following period.

Reset
REQ-029 While rst=1, the block SHALL hold count=0, strobe=0, phase=0, phase_valid=0, locked=0, div_err=0, pend=0, sync_d=0, div_shadow=DEFAULT_DIV and div_act=DEFAULT_DIV.
REQ-030 Reset asserted mid-period SHALL abort that period immediately and discard any pending divisor.
REQ-031 After rst deasserts, counting SHALL start at count=0 on the first clock edge with en=1.

Verification
REQ-032 The bench SHALL cover: DEFAULT_DIV=4, en=1 after reset -> count 1,2,3,0...; strobe high on the 4th edge and then every 4 cycles exactly.
REQ-033 The bench SHALL cover: div_load with div_in=6 at count=1 (div_act=4) -> current period stays 4; the next strobes are 6 cycles apart.
REQ-034 The bench SHALL cover: div_load with div_in=1 -> div_err=1, period unchanged; then div_load with div_in=5 -> accepted, div_err stays 1.
REQ-035 The bench SHALL cover: div_act=8 with a sync edge at count=5 -> strobe next cycle, count restarts at 0, phase=5, phase_valid pulses once, locked=0.
REQ-036 The bench SHALL cover: sync edge at count=7 with div_act=8 -> single strobe, phase=7, locked=1; sync_in held high 20 cycles -> no further phase_valid.
REQ-037 The bench SHALL cover: en=0 for 3 cycles at count=2 -> count stays 2, no strobe, sync ignored; rst pulse at count=3 -> all outputs reset immediately.
